// File: rtl/reconstruct_l7.sv
// -----------------------------------------------------------------------------
// reconstruct_l7 -- seventh-level wavelet synthesis stage (inverse of L7 analysis)
//
// Accepts one a7/d7 coefficient pair (nominally every 8 cycles), upsamples by 2
// and filters with 8-tap rec-lo / rec-hi banks in polyphase form.  Eight shared
// multipliers serve both phases: the even pass runs in the accept cycle, the
// odd pass four cycles later on the shifted history.  One a6 sample is emitted
// every 4 cycles, tagged with its phase.
//
// Datapath per pass: S1 8 products (73 b) -> S2 sum of 8 (76 b) ->
// S3 truncate bits [COEF_FRAC+INTERNAL_WIDTH-1:COEF_FRAC] (wraps, no rounding).
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous reset, active-high
//   din_valid   in   a7_in/d7_in valid this cycle
//   a7_in       in   approximation coefficient, Q25.23
//   d7_in       in   detail coefficient, Q25.23
//   dout_valid  out  a6_out valid (1-cycle pulse)
//   dout_phase  out  0 = even output sample, 1 = odd
//   a6_out      out  reconstructed a6, Q25.23 (holds between pulses)
//   overrun     out  sticky: input arrived while an odd pass was still pending
//
// Build option:
//   RECON_WARMUP_MASK_EN  when defined, dout_valid is suppressed for the
//                         passes of the first 3 accepted inputs (filter fill).
// -----------------------------------------------------------------------------
module reconstruct_l7 #(
  parameter int INTERNAL_WIDTH = 48,
  parameter int COEF_WIDTH     = 25,
  parameter int COEF_FRAC      = 23,
  parameter logic signed [COEF_WIDTH-1:0] REC_LO0 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_LO1 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_LO2 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_LO3 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_LO4 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_LO5 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_LO6 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_LO7 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_HI0 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_HI1 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_HI2 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_HI3 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_HI4 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_HI5 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_HI6 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_HI7 = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din_valid,
  input  logic [INTERNAL_WIDTH-1:0] a7_in,
  input  logic [INTERNAL_WIDTH-1:0] d7_in,
  output logic                      dout_valid,
  output logic                      dout_phase,
  output logic [INTERNAL_WIDTH-1:0] a6_out,
  output logic                      overrun
);

  localparam int PW = INTERNAL_WIDTH + COEF_WIDTH;  // product width
  localparam int SW = PW + 3;                       // sum-of-8 width

  localparam logic signed [COEF_WIDTH-1:0] LO [8] = '{
    REC_LO0, REC_LO1, REC_LO2, REC_LO3, REC_LO4, REC_LO5, REC_LO6, REC_LO7};
  localparam logic signed [COEF_WIDTH-1:0] HI [8] = '{
    REC_HI0, REC_HI1, REC_HI2, REC_HI3, REC_HI4, REC_HI5, REC_HI6, REC_HI7};

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ODD = 1'b1
  } state_t;

  state_t                            state;
  logic [1:0]                        cnt;
  logic signed [INTERNAL_WIDTH-1:0]  a_hist [4];
  logic signed [INTERNAL_WIDTH-1:0]  d_hist [4];

  // Pipeline control (reset) and data (not reset)
  logic                              s1_valid, s1_phase, s1_mask;
  logic                              s2_valid, s2_phase, s2_mask;
  logic signed [PW-1:0]              prod [8];
  logic signed [SW-1:0]              s2_sum;

  // Pass control
  logic issue_odd;
  logic odd_busy;
  logic accept;
  logic pass_valid;
  logic pass_mask;

  // The odd pass is issued when the wait counter expires.
  assign issue_odd  = (state == WAIT_ODD) && (cnt == 2'd0);

  // An odd pass counts as pending from the accept until it has left S2, so a
  // new even pass can never overlap it in the shared multipliers or in the
  // output register.
  assign odd_busy   = (state == WAIT_ODD) || (s1_valid && s1_phase) ||
                      (s2_valid && s2_phase);
  assign accept     = din_valid && !odd_busy;
  assign pass_valid = accept || issue_odd;

  // ---------------------------------------------------------------------------
  // Warm-up masking: tag passes of the first three accepted inputs.
  // ---------------------------------------------------------------------------
`ifdef RECON_WARMUP_MASK_EN
  logic [1:0] fill_cnt;
  logic       odd_mask_q;
  logic       even_mask;

  assign even_mask = (fill_cnt != 2'd3);
  assign pass_mask = issue_odd ? odd_mask_q : even_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt   <= 2'd0;
      odd_mask_q <= 1'b0;
    end else if (accept) begin
      // The odd pass of this input inherits the even pass's mask decision.
      odd_mask_q <= even_mask;
      if (fill_cnt != 2'd3) fill_cnt <= fill_cnt + 2'd1;
    end
  end
`else
  assign pass_mask = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM, history shift registers and sticky overrun.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      overrun <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        a_hist[k] <= '0;
        d_hist[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= WAIT_ODD;
            cnt   <= 2'd3;
          end
        end
        WAIT_ODD: begin
          if (cnt == 2'd0) state <= IDLE;
          else             cnt   <= cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        a_hist[0] <= a7_in;
        d_hist[0] <= d7_in;
        for (int k = 1; k < 4; k++) begin
          a_hist[k] <= a_hist[k-1];
          d_hist[k] <= d_hist[k-1];
        end
      end

      // Dropped input: history is left untouched, flag stays until reset.
      if (din_valid && !accept) overrun <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand selection for the shared multipliers.
  //   even: samples {in, h0, h1, h2} with taps 0,2,4,6
  //   odd : samples {h0, h1, h2, h3} with taps 1,3,5,7 (history already shifted)
  // ---------------------------------------------------------------------------
  logic signed [INTERNAL_WIDTH-1:0] a_op [4];
  logic signed [INTERNAL_WIDTH-1:0] d_op [4];
  logic signed [COEF_WIDTH-1:0]     lo_c [4];
  logic signed [COEF_WIDTH-1:0]     hi_c [4];

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a_op[k] = '0;
      d_op[k] = '0;
      lo_c[k] = LO[2*k];
      hi_c[k] = HI[2*k];
    end
    if (issue_odd) begin
      for (int k = 0; k < 4; k++) begin
        a_op[k] = a_hist[k];
        d_op[k] = d_hist[k];
        lo_c[k] = LO[2*k+1];
        hi_c[k] = HI[2*k+1];
      end
    end else begin
      a_op[0] = a7_in;
      d_op[0] = d7_in;
      for (int k = 1; k < 4; k++) begin
        a_op[k] = a_hist[k-1];
        d_op[k] = d_hist[k-1];
      end
    end
  end

  // Full-precision signed product; both operands sign-extended to PW so the
  // low PW bits of the product are exact.
  function automatic logic signed [PW-1:0] smul(
    input logic signed [INTERNAL_WIDTH-1:0] x,
    input logic signed [COEF_WIDTH-1:0]     c
  );
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ce;
    xe = {{COEF_WIDTH{x[INTERNAL_WIDTH-1]}}, x};
    ce = {{INTERNAL_WIDTH{c[COEF_WIDTH-1]}}, c};
    return xe * ce;
  endfunction

  // ---------------------------------------------------------------------------
  // S1: products
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_phase <= 1'b0;
      s1_mask  <= 1'b0;
    end else begin
      s1_valid <= pass_valid;
      s1_phase <= issue_odd;
      s1_mask  <= pass_mask;
    end
  end

  // NOTE: wide datapath registers carry no reset; the reset valid bits keep
  // their stale contents from ever reaching the outputs.
  always_ff @(posedge clk) begin
    if (pass_valid) begin
      for (int k = 0; k < 4; k++) begin
        prod[k]   <= smul(a_op[k], lo_c[k]);
        prod[k+4] <= smul(d_op[k], hi_c[k]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: sum of eight products, 3 guard bits so the sum itself never overflows
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int j = 0; j < 8; j++) begin
      sum_c = sum_c + $signed({{3{prod[j][PW-1]}}, prod[j]});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_phase <= 1'b0;
      s2_mask  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_phase <= s1_phase;
      s2_mask  <= s1_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid) s2_sum <= sum_c;
  end

  // ---------------------------------------------------------------------------
  // S3: truncate back to Q25.23 (plain bit select: no rounding, wraps on
  // overflow) and register the outputs.  a6_out/dout_phase follow every pass,
  // masked or not, and hold between passes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_phase <= 1'b0;
      a6_out     <= '0;
    end else begin
      dout_valid <= s2_valid && !s2_mask;
      if (s2_valid) begin
        dout_phase <= s2_phase;
        a6_out     <= s2_sum[COEF_FRAC+INTERNAL_WIDTH-1:COEF_FRAC];
      end
    end
  end

endmodule
